// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame sequencer feeding the UART transmitter: buffers core writes
// and presents one byte at a time with the send opcode until TxDone rises.
module uart_tx_feeder #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [5:0]  SEND_OPCODE = 6'b000001,
    parameter logic [5:0]  IDLE_OPCODE = 6'b000000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Wr_en,
    input  logic [7:0]               Wr_data,
    input  logic                     TxDone,
    output logic [5:0]               Opcode,
    output logic [7:0]               Data_send,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Busy,
    output logic                     Overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            txdone_q;
    logic            wr_ok;
    logic            pop;
    logic            done_rise;
    logic [CW-1:0]   count_nxt;

    // Full/Empty are the registered flags from the previous edge, so a same-edge pop
    // never makes room for a write.
    always_comb begin
        wr_ok     = Wr_en & ~Full;
        pop       = (state == IDLE) & ~Empty;
        done_rise = TxDone & ~txdone_q;
        count_nxt = Count + CW'(wr_ok) - CW'(pop);
    end

    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= Wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Opcode    <= IDLE_OPCODE;
            Data_send <= 8'h00;
            Count     <= '0;
            Empty     <= 1'b1;
            Full      <= 1'b0;
            Busy      <= 1'b0;
            Overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            txdone_q  <= 1'b0;
        end else begin
            txdone_q <= TxDone;
            Count    <= count_nxt;
            Full     <= (count_nxt == CW'(DEPTH));
            Empty    <= (count_nxt == '0);
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (Wr_en && Full) begin
                Overflow <= 1'b1;
            end

            // GAP guarantees one idle opcode cycle between consecutive frames.
            case (state)
                IDLE: begin
                    Opcode <= IDLE_OPCODE;
                    Busy   <= 1'b0;
                    if (pop) begin
                        Data_send <= mem[rd_ptr];
                        rd_ptr    <= rd_ptr + AW'(1);
                        Opcode    <= SEND_OPCODE;
                        Busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (done_rise) begin
                        Opcode <= IDLE_OPCODE;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Opcode <= IDLE_OPCODE;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
